fetch_ref_wr_ctrl: RTL and testbench

Upstream write controller for the 64-entry x 48-pixel single-port reference fetch buffer in the H.265 encoder fetch stage. It accepts 16-pixel beats from the external-memory read path over a valid/ready handshake and packs every three beats into one 48-pixel row. It then drives the buffer's write port (enable, 6-bit address, 48-pixel data) and reports completion of a row-load job. The buffer gives write priority over read, so the downstream read scheduler uses `busy_o` to avoid reading during a load.

---
 rtl/fetch_ref_wr_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_ref_wr_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ref_wr_ctrl.sv
// fetch_ref_wr_ctrl: upstream write controller for the 64 x 48-pixel reference
// fetch buffer. Packs three 16-pixel beats into one row and writes it out.
// Optional macro FETCH_WR_PAD_EN: after a short job, the last real row is
// replicated into the remaining addresses (bottom-edge padding).
module fetch_ref_wr_ctrl #(
    parameter int PIXEL_WIDTH = 8,
    parameter int ROW_MAX     = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start_i,
    input  logic [6:0]                 row_num_i,
    input  logic                       din_valid_i,
    input  logic [16*PIXEL_WIDTH-1:0]  din_data_i,
    output logic                       din_ready_o,
    output logic                       wrif_en_o,
    output logic [5:0]                 wrif_addr_o,
    output logic [48*PIXEL_WIDTH-1:0]  wrif_data_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int         BEAT_W  = 16 * PIXEL_WIDTH;
    localparam logic [6:0] ROW_LIM = 7'(ROW_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
`ifdef FETCH_WR_PAD_EN
        , PAD = 2'd3
`endif
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [6:0]          rows;
    logic [1:0]          beat_cnt;
    logic [5:0]          row_cnt;
    // Set once the last row's third beat is taken; holds off further beats
    // for the cycle in which that final write is on the port.
    logic                drain;
    logic [2*BEAT_W-1:0] pack;
    logic                accept;
    logic                third;
    logic                last_row;
`ifdef FETCH_WR_PAD_EN
    logic [6:0]          pad_cnt;
`endif

    assign accept   = din_valid_i && din_ready_o;
    assign third    = accept && (beat_cnt == 2'd2);
    assign last_row = ({1'b0, row_cnt} == (rows - 7'd1));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = (row_num_i == 7'd0) ? DONE : LOAD;
            end
            LOAD: begin
                if (drain) begin
                    state_nxt = DONE;
`ifdef FETCH_WR_PAD_EN
                    if (rows < ROW_LIM) state_nxt = PAD;
`endif
                end
            end
`ifdef FETCH_WR_PAD_EN
            PAD: begin
                if (pad_cnt == ROW_LIM) state_nxt = DONE;
            end
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        din_ready_o = (state == LOAD) && !drain;
        busy_o      = (state != IDLE);
        done_o      = (state == DONE);
    end

    // Job counters, beat packing and registered buffer write port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rows        <= '0;
            beat_cnt    <= '0;
            row_cnt     <= '0;
            drain       <= 1'b0;
            pack        <= '0;
            wrif_en_o   <= 1'b0;
            wrif_addr_o <= '0;
            wrif_data_o <= '0;
`ifdef FETCH_WR_PAD_EN
            pad_cnt     <= '0;
`endif
        end else begin
            wrif_en_o <= 1'b0;
            if (state == IDLE && start_i) begin
                rows     <= (row_num_i > ROW_LIM) ? ROW_LIM : row_num_i;
                beat_cnt <= '0;
                row_cnt  <= '0;
                drain    <= 1'b0;
            end
            if (accept) begin
                case (beat_cnt)
                    2'd0:    pack[2*BEAT_W-1:BEAT_W] <= din_data_i;
                    2'd1:    pack[BEAT_W-1:0]        <= din_data_i;
                    default: begin
                        wrif_en_o   <= 1'b1;
                        wrif_addr_o <= row_cnt;
                        wrif_data_o <= {pack, din_data_i};
                    end
                endcase
                beat_cnt <= third ? 2'd0 : beat_cnt + 2'd1;
                if (third) begin
                    row_cnt <= row_cnt + 6'd1;
                    if (last_row) drain <= 1'b1;
                end
            end
`ifdef FETCH_WR_PAD_EN
            // Padding reuses wrif_data_o as-is: it still holds the last real row.
            if (state == LOAD && drain && rows < ROW_LIM) begin
                wrif_en_o   <= 1'b1;
                wrif_addr_o <= rows[5:0];
                pad_cnt     <= rows + 7'd1;
            end
            if (state == PAD && pad_cnt != ROW_LIM) begin
                wrif_en_o   <= 1'b1;
                wrif_addr_o <= pad_cnt[5:0];
                pad_cnt     <= pad_cnt + 7'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_ref_wr_ctrl.sv
// Directed bench for fetch_ref_wr_ctrl. Follows FETCH_WR_PAD_EN when choosing
// the expected outcome of the short (60-row) job.
module tb_fetch_ref_wr_ctrl;

    localparam int PW = 8;
    localparam int BW = 16 * PW;
    localparam int RW = 48 * PW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0;
    logic [6:0]    row_num_i = '0;
    logic          din_valid_i = 1'b0;
    logic [BW-1:0] din_data_i = '0;
    logic          din_ready_o;
    logic          wrif_en_o;
    logic [5:0]    wrif_addr_o;
    logic [RW-1:0] wrif_data_o;
    logic          busy_o;
    logic          done_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [5:0]    wa[$];
    logic [RW-1:0] wd[$];
    int            wc[$];
    int            dc[$];

    fetch_ref_wr_ctrl #(.PIXEL_WIDTH(PW), .ROW_MAX(64)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .row_num_i(row_num_i),
        .din_valid_i(din_valid_i), .din_data_i(din_data_i), .din_ready_o(din_ready_o),
        .wrif_en_o(wrif_en_o), .wrif_addr_o(wrif_addr_o), .wrif_data_o(wrif_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every buffer write and done pulse mid-cycle
    always @(negedge clk) begin
        if (wrif_en_o) begin
            wa.push_back(wrif_addr_o);
            wd.push_back(wrif_data_o);
            wc.push_back(cyc);
        end
        if (done_o) dc.push_back(cyc);
    end

    function automatic logic [BW-1:0] beat_val(input int r, input int k);
        logic [7:0] a;
        logic [7:0] b;
        a = r[7:0];
        b = 8'hA0 + k[7:0];
        return {8{a, b}};
    endfunction

    function automatic logic [RW-1:0] exp_row(input int r);
        return {beat_val(r, 0), beat_val(r, 1), beat_val(r, 2)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete(); dc.delete();
    endtask

    task automatic start_job(input logic [6:0] n, output int t);
        start_i   = 1'b1;
        row_num_i = n;
        t = cyc;
        step();
        start_i = 1'b0;
    endtask

    // Present beats first..first+nbeats-1; returns just after the last transfer edge
    task automatic feed(input int first, input int nbeats, input bit toggle, input int base);
        int idx;
        int guard;
        bit v;
        idx = first; guard = 0; v = 1'b1;
        while (idx < first + nbeats && guard < nbeats * 4 + 20) begin
            din_valid_i = v;
            din_data_i  = beat_val(base + idx / 3, idx % 3);
            if (v && din_ready_o) idx++;
            step();
            guard++;
            if (toggle) v = !v;
        end
        din_valid_i = 1'b0;
        total++;
        if (idx != first + nbeats) begin
            bad++;
            $display("FAIL feed_timeout: beats accepted=%0d required=%0d", idx - first, nbeats);
        end
    endtask

    task automatic wait_done(input int budget);
        int g;
        g = 0;
        while (dc.size() == 0 && g < budget) begin
            step();
            g++;
        end
        total++;
        if (dc.size() == 0) begin
            bad++;
            $display("FAIL wait_done: no done_o within %0d cycles", budget);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        total++; if (din_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", din_ready_o); end
        total++; if (wrif_en_o !== 1'b0) begin bad++; $display("FAIL rst_en: got %b want 0", wrif_en_o); end
        total++; if (wrif_addr_o !== 6'd0) begin bad++; $display("FAIL rst_addr: got %0d want 0", wrif_addr_o); end
        total++; if (wrif_data_o !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", wrif_data_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done_o); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_full_load();
        int t;
        int d0;
        clear_log();
        start_job(7'd64, t);
        total++; if (busy_o !== 1'b1 || din_ready_o !== 1'b1) begin bad++; $display("FAIL full_start: busy=%b ready=%b want 1 1", busy_o, din_ready_o); end
        feed(0, 192, 1'b0, 0);
        total++; if (din_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready_drop: got %b want 0", din_ready_o); end
        wait_done(20);
        total++; if (wa.size() != 64) begin bad++; $display("FAIL full_count: got %0d want 64", wa.size()); end
        for (int i = 0; i < wa.size() && i < 64; i++) begin
            total++;
            if (wa[i] !== 6'(i) || wd[i] !== exp_row(i)) begin
                bad++;
                $display("FAIL full_row%0d: addr=%0d data=%h want addr=%0d data=%h", i, wa[i], wd[i], i, exp_row(i));
            end
        end
        total++; if (wc.size() < 1 || wc[0] != t + 4) begin bad++; $display("FAIL full_first_wr: got cycle %0d want %0d", (wc.size() > 0) ? wc[0] - t : -1, 4); end
        d0 = (dc.size() > 0) ? dc[0] - t : -1;
        total++; if (dc.size() != 1 || d0 != 194) begin bad++; $display("FAIL full_done: count=%0d at T+%0d want 1 at T+194", dc.size(), d0); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL full_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_toggle_2rows();
        int t;
        clear_log();
        start_job(7'd2, t);
        feed(0, 6, 1'b1, 10);
        total++; if (din_ready_o !== 1'b0) begin bad++; $display("FAIL tog_ready_drop: got %b want 0", din_ready_o); end
        wait_done(20);
        total++; if (wa.size() != 2) begin bad++; $display("FAIL tog_count: got %0d want 2", wa.size()); end
        for (int i = 0; i < wa.size() && i < 2; i++) begin
            total++;
            if (wa[i] !== 6'(i) || wd[i] !== exp_row(10 + i)) begin
                bad++;
                $display("FAIL tog_row%0d: addr=%0d data=%h want addr=%0d data=%h", i, wa[i], wd[i], i, exp_row(10 + i));
            end
        end
        total++; if (dc.size() != 1) begin bad++; $display("FAIL tog_done_count: got %0d want 1", dc.size()); end
    endtask

    task automatic test_zero_rows();
        int t;
        clear_log();
        start_job(7'd0, t);
        total++; if (done_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL zero_done_t1: done=%b busy=%b want 1 1", done_o, busy_o); end
        step();
        total++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL zero_done_t2: done=%b busy=%b want 0 0", done_o, busy_o); end
        step();
        total++; if (wa.size() != 0 || dc.size() != 1) begin bad++; $display("FAIL zero_writes: writes=%0d dones=%0d want 0 1", wa.size(), dc.size()); end
    endtask

    task automatic test_clamp();
        int t;
        clear_log();
        start_job(7'd100, t);
        feed(0, 192, 1'b0, 3);
        wait_done(20);
        total++; if (wa.size() != 64) begin bad++; $display("FAIL clamp_count: got %0d want 64", wa.size()); end
        total++; if (wa.size() < 64 || wa[63] !== 6'd63 || wd[63] !== exp_row(66)) begin bad++; $display("FAIL clamp_last: size=%0d want last addr 63", wa.size()); end
        total++; if (dc.size() != 1) begin bad++; $display("FAIL clamp_done_count: got %0d want 1", dc.size()); end
    endtask

    task automatic test_pad();
        int t;
        int nexp;
        int r;
`ifdef FETCH_WR_PAD_EN
        nexp = 64;
`else
        nexp = 60;
`endif
        clear_log();
        start_job(7'd60, t);
        feed(0, 180, 1'b0, 0);
        wait_done(30);
        total++; if (wa.size() != nexp) begin bad++; $display("FAIL pad_count: got %0d want %0d", wa.size(), nexp); end
        for (int i = 0; i < wa.size() && i < nexp; i++) begin
            r = (i < 60) ? i : 59;
            total++;
            if (wa[i] !== 6'(i) || wd[i] !== exp_row(r)) begin
                bad++;
                $display("FAIL pad_row%0d: addr=%0d data=%h want addr=%0d data=%h", i, wa[i], wd[i], i, exp_row(r));
            end
            if (i >= 60) begin
                total++;
                if (wc[i] != wc[59] + (i - 59)) begin bad++; $display("FAIL pad_cycle%0d: got +%0d want +%0d", i, wc[i] - wc[59], i - 59); end
            end
        end
        total++;
        if (dc.size() != 1 || wc.size() != nexp || dc[0] != wc[nexp-1] + 1) begin
            bad++;
            $display("FAIL pad_done: dones=%0d writes=%0d want done one cycle after last write", dc.size(), wc.size());
        end
    endtask

    task automatic test_reset_mid();
        int t;
        bit hit1;
        clear_log();
        start_job(7'd2, t);
        feed(0, 4, 1'b0, 30);
        rstn = 1'b0;
        #1;
        total++; if (din_ready_o !== 1'b0 || wrif_en_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl: ready=%b en=%b busy=%b done=%b want 0", din_ready_o, wrif_en_o, busy_o, done_o); end
        total++; if (wrif_addr_o !== 6'd0 || wrif_data_o !== '0) begin bad++; $display("FAIL mid_rst_port: addr=%0d data=%h want 0", wrif_addr_o, wrif_data_o); end
        repeat (3) step();
        rstn = 1'b1;
        repeat (4) step();
        hit1 = 1'b0;
        foreach (wa[i]) if (wa[i] == 6'd1) hit1 = 1'b1;
        total++; if (hit1 || wa.size() != 1) begin bad++; $display("FAIL mid_rst_writes: writes=%0d addr1_seen=%b want 1 0", wa.size(), hit1); end
        clear_log();
        start_job(7'd1, t);
        feed(0, 3, 1'b0, 40);
        wait_done(20);
        total++;
        if (wa.size() != 1 || wa[0] !== 6'd0 || wd[0] !== exp_row(40)) begin
            bad++;
            $display("FAIL mid_rst_fresh: writes=%0d want one write addr 0 data %h", wa.size(), exp_row(40));
        end
    endtask

    task automatic test_start_ignored();
        int t;
        clear_log();
        din_valid_i = 1'b1;
        din_data_i  = beat_val(7, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (din_ready_o !== 1'b0) begin bad++; $display("FAIL idle_ready%0d: got %b want 0", i, din_ready_o); end
        end
        din_valid_i = 1'b0;
        total++; if (wa.size() != 0) begin bad++; $display("FAIL idle_writes: got %0d want 0", wa.size()); end
        start_job(7'd1, t);
        feed(0, 2, 1'b0, 20);
        start_i   = 1'b1;
        row_num_i = 7'd5;
        step();
        start_i = 1'b0;
        feed(2, 1, 1'b0, 20);
        wait_done(20);
        total++;
        if (wa.size() != 1 || wa[0] !== 6'd0 || wd[0] !== exp_row(20)) begin
            bad++;
            $display("FAIL midstart_writes: writes=%0d want one write addr 0 data %h", wa.size(), exp_row(20));
        end
        total++; if (dc.size() != 1 || busy_o !== 1'b0) begin bad++; $display("FAIL midstart_done: dones=%0d busy=%b want 1 0", dc.size(), busy_o); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_toggle_2rows();
        test_zero_rows();
        test_clamp();
        test_pad();
        test_reset_mid();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
